// File: rtl/stream_pkg.sv
// Shared types for the stream cells: demux FSM states and a select-width helper.
package stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    DROP
  } demux_state_e;

  // Select width for n channels, never below one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_hold_reg.sv
// One-entry register slice holding payload, last flag and destination.
// Push and pop may coincide; the caller only pushes when the slot is free or draining.
module stream_hold_reg #(
  parameter int DATA_W = 8,
  parameter int DST_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic [DST_W-1:0]  push_dst,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic [DST_W-1:0]  dst
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      // NOTE: payload is reset as well because downstream reads it while valid is low.
      data  <= '0;
      last  <= 1'b0;
      dst   <= '0;
    end else if (push) begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      valid <= 1'b1;
      data  <= push_data;
      last  <= push_last;
      dst   <= push_dst;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1:N packet demultiplexer: select locked on the first beat,
// out-of-range packets discarded and counted.
module stream_demux
  import stream_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int N_OUT  = 2,
  parameter  int CNT_W  = 8,
  localparam int SEL_W  = sel_width(N_OUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic [SEL_W-1:0]  s_sel,
  output logic [N_OUT-1:0]  m_valid,
  input  logic [N_OUT-1:0]  m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              drop_err,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam logic [SEL_W:0] N_OUT_EXT = N_OUT[SEL_W:0];

  demux_state_e     state;
  logic [SEL_W-1:0] cur_dst;
  logic             hold_valid;
  logic [SEL_W-1:0] hold_dst;
  logic             in_range;
  logic             hold_ready;
  logic             accept;
  logic             push;
  logic             pop;
  logic [SEL_W-1:0] push_dst;

  assign in_range   = {1'b0, s_sel} < N_OUT_EXT;
  assign hold_ready = !hold_valid || m_ready[hold_dst];
  assign s_ready    = (state == DROP) || ((state == IDLE) && !in_range) || hold_ready;
  assign accept     = s_valid && s_ready;
  assign push       = accept && (((state == IDLE) && in_range) || (state == ROUTE));
  assign pop        = hold_valid && m_ready[hold_dst];
  assign push_dst   = (state == IDLE) ? s_sel : cur_dst;

  stream_hold_reg #(
    .DATA_W (DATA_W),
    .DST_W  (SEL_W)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (s_data),
    .push_last (s_last),
    .push_dst  (push_dst),
    .valid     (hold_valid),
    .data      (m_data),
    .last      (m_last),
    .dst       (hold_dst)
  );

  always_comb begin
    // NOTE: default first so no path through the loop can infer a latch.
    m_valid = '0;
    for (int i = 0; i < N_OUT; i++) begin
      m_valid[i] = hold_valid && (hold_dst == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur_dst  <= '0;
      drop_err <= 1'b0;
      drop_cnt <= '0;
    end else begin
      drop_err <= 1'b0;
      if (accept) begin
        unique case (state)
          IDLE: begin
            if (in_range) begin
              cur_dst <= s_sel;
              if (!s_last) state <= ROUTE;
            end else begin
              // Only the first beat of a discarded packet is reported and counted.
              drop_err <= 1'b1;
              if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
              if (!s_last) state <= DROP;
            end
          end
          ROUTE:   if (s_last) state <= IDLE;
          DROP:    if (s_last) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench: a 2-channel instance for routing and back-pressure,
// a 3-channel instance with a 2-bit counter for drop and saturation.
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic       s_valid2, s_ready2, s_last2, m_last2, drop_err2;
  logic [7:0] s_data2, m_data2, drop_cnt2;
  logic [0:0] s_sel2;
  logic [1:0] m_valid2, m_ready2;

  logic       s_valid3, s_ready3, s_last3, m_last3, drop_err3;
  logic [7:0] s_data3, m_data3;
  logic [1:0] s_sel3, drop_cnt3;
  logic [2:0] m_valid3, m_ready3;

  stream_demux #(.DATA_W(8), .N_OUT(2), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .s_last(s_last2), .s_sel(s_sel2), .m_valid(m_valid2), .m_ready(m_ready2),
    .m_data(m_data2), .m_last(m_last2), .drop_err(drop_err2), .drop_cnt(drop_cnt2)
  );

  stream_demux #(.DATA_W(8), .N_OUT(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3),
    .s_last(s_last3), .s_sel(s_sel3), .m_valid(m_valid3), .m_ready(m_ready3),
    .m_data(m_data3), .m_last(m_last3), .drop_err(drop_err3), .drop_cnt(drop_cnt3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    s_valid2 = 1'b0; s_data2 = 8'h00; s_last2 = 1'b0; s_sel2 = 1'b0; m_ready2 = 2'b00;
    s_valid3 = 1'b0; s_data3 = 8'h00; s_last3 = 1'b0; s_sel3 = 2'd0; m_ready3 = 3'b000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (m_valid2 !== 2'b00) begin failures++; $display("FAIL reset_m_valid got=%b exp=00", m_valid2); end
    checks++; if (drop_cnt2 !== 8'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt2); end
    checks++; if (s_ready2 !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready2); end
    checks++; if (m_data2 !== 8'h00 || m_last2 !== 1'b0 || drop_err2 !== 1'b0)
      begin failures++; $display("FAIL reset_outs data=%h last=%b err=%b exp=00/0/0", m_data2, m_last2, drop_err2); end
    // Load a beat that stalls on channel 0, then reset between edges.
    s_valid2 = 1'b1; s_data2 = 8'h11; s_sel2 = 1'b0; s_last2 = 1'b1;
    tick();
    s_valid2 = 1'b0;
    checks++; if (m_valid2 !== 2'b01) begin failures++; $display("FAIL preload_m_valid got=%b exp=01", m_valid2); end
    checks++; if (s_ready2 !== 1'b0) begin failures++; $display("FAIL preload_s_ready got=%b exp=0", s_ready2); end
    #3 rst = 1'b1;
    #1;
    checks++; if (m_valid2 !== 2'b00) begin failures++; $display("FAIL async_m_valid got=%b exp=00", m_valid2); end
    checks++; if (m_data2 !== 8'h00) begin failures++; $display("FAIL async_m_data got=%h exp=00", m_data2); end
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_single_beat;
    m_ready2 = 2'b11;
    s_valid2 = 1'b1; s_data2 = 8'hA5; s_sel2 = 1'b1; s_last2 = 1'b1;
    tick();
    s_valid2 = 1'b0;
    checks++; if (m_valid2 !== 2'b10 || m_data2 !== 8'hA5 || m_last2 !== 1'b1)
      begin failures++; $display("FAIL single_out valid=%b data=%h last=%b exp=10/a5/1", m_valid2, m_data2, m_last2); end
    tick();
    checks++; if (m_valid2 !== 2'b00) begin failures++; $display("FAIL single_drain got=%b exp=00", m_valid2); end
  endtask

  task automatic test_select_lock;
    logic [7:0] exp_data [3] = '{8'h01, 8'h02, 8'h03};
    logic       exp_last [3] = '{1'b0, 1'b0, 1'b1};
    m_ready2 = 2'b11;
    for (int i = 0; i < 3; i++) begin
      s_valid2 = 1'b1; s_data2 = exp_data[i]; s_last2 = exp_last[i];
      s_sel2   = (i == 0) ? 1'b0 : 1'b1;
      tick();
      checks++; if (m_valid2 !== 2'b01 || m_data2 !== exp_data[i] || m_last2 !== exp_last[i])
        begin failures++; $display("FAIL lock_beat%0d valid=%b data=%h last=%b exp=01/%h/%b",
                                   i, m_valid2, m_data2, m_last2, exp_data[i], exp_last[i]); end
    end
    s_valid2 = 1'b0;
    tick();
    checks++; if (m_valid2 !== 2'b00) begin failures++; $display("FAIL lock_drain got=%b exp=00", m_valid2); end
  endtask

  task automatic test_back_pressure;
    logic [7:0] exp_data [3] = '{8'h10, 8'h11, 8'h12};
    m_ready2 = 2'b10;
    s_valid2 = 1'b1; s_data2 = 8'h10; s_sel2 = 1'b0; s_last2 = 1'b0;
    tick();
    s_data2 = 8'h11;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (s_ready2 !== 1'b0 || m_valid2 !== 2'b01 || m_data2 !== 8'h10)
        begin failures++; $display("FAIL bp_stall%0d ready=%b valid=%b data=%h exp=0/01/10", c, s_ready2, m_valid2, m_data2); end
      tick();
    end
    m_ready2 = 2'b01;
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++; if (m_valid2 !== 2'b01 || m_data2 !== exp_data[i] || m_last2 !== (i == 2))
        begin failures++; $display("FAIL bp_resume%0d valid=%b data=%h last=%b exp=01/%h", i, m_valid2, m_data2, m_last2, exp_data[i]); end
      s_data2 = 8'h12; s_last2 = 1'b1;
      if (i == 2) s_valid2 = 1'b0;
    end
    tick();
    checks++; if (m_valid2 !== 2'b00) begin failures++; $display("FAIL bp_drain got=%b exp=00", m_valid2); end
  endtask

  task automatic test_drop;
    m_ready3 = 3'b111;
    s_valid3 = 1'b1; s_data3 = 8'hDD; s_sel3 = 2'd3; s_last3 = 1'b0;
    #1;
    checks++; if (s_ready3 !== 1'b1) begin failures++; $display("FAIL drop_ready0 got=%b exp=1", s_ready3); end
    tick();
    s_data3 = 8'hDE; s_sel3 = 2'd0; s_last3 = 1'b1;
    #1;
    checks++; if (s_ready3 !== 1'b1 || m_valid3 !== 3'b000 || drop_err3 !== 1'b1 || drop_cnt3 !== 2'd1)
      begin failures++; $display("FAIL drop_beat1 ready=%b valid=%b err=%b cnt=%0d exp=1/000/1/1", s_ready3, m_valid3, drop_err3, drop_cnt3); end
    tick();
    s_data3 = 8'h5A; s_sel3 = 2'd2; s_last3 = 1'b1;
    #1;
    checks++; if (m_valid3 !== 3'b000 || drop_err3 !== 1'b0 || drop_cnt3 !== 2'd1)
      begin failures++; $display("FAIL drop_tail valid=%b err=%b cnt=%0d exp=000/0/1", m_valid3, drop_err3, drop_cnt3); end
    tick();
    s_valid3 = 1'b0;
    checks++; if (m_valid3 !== 3'b100 || m_data3 !== 8'h5A)
      begin failures++; $display("FAIL drop_next valid=%b data=%h exp=100/5a", m_valid3, m_data3); end
    tick();
  endtask

  task automatic test_saturation;
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b1;
    #1;
    checks++; if (drop_cnt3 !== 2'd0) begin failures++; $display("FAIL sat_reset got=%0d exp=0", drop_cnt3); end
    tick();
    rst = 1'b0;
    s_valid3 = 1'b1; s_data3 = 8'h00; s_sel3 = 2'd3; s_last3 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (drop_err3 !== 1'b1 || drop_cnt3 !== exp_cnt[k])
        begin failures++; $display("FAIL sat_drop%0d err=%b cnt=%0d exp=1/%0d", k, drop_err3, drop_cnt3, exp_cnt[k]); end
    end
    s_valid3 = 1'b0;
    tick();
    checks++; if (drop_err3 !== 1'b0 || drop_cnt3 !== 2'd3)
      begin failures++; $display("FAIL sat_idle err=%b cnt=%0d exp=0/3", drop_err3, drop_cnt3); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_select_lock();
    test_back_pressure();
    test_drop();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
